// File: rtl/tohost_monitor.sv
// Monitors cpu->dmem store ports for riscv-tests tohost writes, decodes pass/fail/test number,
// raises a sticky halt request and runs a cycle watchdog while the test executes.
module tohost_monitor #(
    parameter int                XLEN           = 32,
    parameter int                NUM_PORTS      = 1,
    parameter logic [XLEN-1:0]   TOHOST_ADDR    = 'h1000,
    parameter int                TIMEOUT_CYCLES = 100000,
    parameter int                CNT_W          = 32
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          start,
    input  logic [NUM_PORTS*XLEN/8-1:0]   mem_we,
    input  logic [NUM_PORTS*XLEN-1:0]     mem_addr,
    input  logic [NUM_PORTS*XLEN-1:0]     mem_wdata,
    output logic                          busy,
    output logic                          done,
    output logic [1:0]                    status,
    output logic [XLEN-2:0]               fail_code,
    output logic [CNT_W-1:0]              cycle_count,
    output logic                          halt_req,
    output logic [2:0]                    state_dbg
);

    localparam int BE_W = XLEN / 8;
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    state_t state, next_state;

    logic            hit_valid;
    logic [XLEN-1:0] hit_data;
    logic            wd_expire;

    // Scan from the highest port down so the lowest port with a nonzero value wins.
    always_comb begin
        hit_valid = 1'b0;
        hit_data  = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if ((|mem_we[p*BE_W +: BE_W]) &&
                (mem_addr[p*XLEN +: XLEN] == TOHOST_ADDR) &&
                (mem_wdata[p*XLEN +: XLEN] != '0)) begin
                hit_valid = 1'b1;
                hit_data  = mem_wdata[p*XLEN +: XLEN];
            end
        end
    end

    assign wd_expire = (TIMEOUT_CYCLES > 0) && (cycle_count == TO_LAST);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (hit_valid) begin
                    next_state = (hit_data == XLEN'(1)) ? ST_PASS : ST_FAIL;
                end else if (wd_expire) begin
                    next_state = ST_TIMEOUT;
                end
            end
            default: next_state = state;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        status    = 2'd0;
        state_dbg = state;
        case (state)
            ST_RUN:     busy = 1'b1;
            ST_PASS:    begin done = 1'b1; status = 2'd1; end
            ST_FAIL:    begin done = 1'b1; status = 2'd2; end
            ST_TIMEOUT: begin done = 1'b1; status = 2'd3; end
            default:    ;
        endcase
        halt_req = done;
    end

    // The counter stops on the edge that leaves RUN, so it holds the last RUN value.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cycle_count <= '0;
            fail_code   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cycle_count <= '0;
                    end
                end
                ST_RUN: begin
                    if (next_state == ST_RUN && cycle_count != '1) begin
                        cycle_count <= cycle_count + CNT_W'(1);
                    end
                    if (next_state == ST_FAIL) begin
                        fail_code <= hit_data[XLEN-1:1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tohost_monitor.sv
// Bench for tohost_monitor: a 2-port, 16-cycle-watchdog instance for the protocol scenarios and
// a 1-port instance with a 4-bit counter and no watchdog for saturation.
module tb_tohost_monitor;

    logic        clk;
    logic        sys_rst;
    logic        start;
    logic [7:0]  mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic [30:0] fail_code;
    logic [31:0] cycle_count;
    logic        halt_req;
    logic [2:0]  state_dbg;

    logic        rst2;
    logic        start2;
    logic [3:0]  we2;
    logic [31:0] addr2;
    logic [31:0] wdata2;
    logic        busy2;
    logic        done2;
    logic [1:0]  status2;
    logic [30:0] fail_code2;
    logic [3:0]  cycle_count2;
    logic        halt_req2;
    logic [2:0]  state_dbg2;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    tohost_monitor #(
        .XLEN(32), .NUM_PORTS(2), .TOHOST_ADDR(32'h1000), .TIMEOUT_CYCLES(16), .CNT_W(32)
    ) dut (
        .sys_clk(clk), .sys_rst(sys_rst), .start(start),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .status(status), .fail_code(fail_code),
        .cycle_count(cycle_count), .halt_req(halt_req), .state_dbg(state_dbg)
    );

    tohost_monitor #(
        .XLEN(32), .NUM_PORTS(1), .TOHOST_ADDR(32'h1000), .TIMEOUT_CYCLES(0), .CNT_W(4)
    ) dut_sat (
        .sys_clk(clk), .sys_rst(rst2), .start(start2),
        .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2),
        .busy(busy2), .done(done2), .status(status2), .fail_code(fail_code2),
        .cycle_count(cycle_count2), .halt_req(halt_req2), .state_dbg(state_dbg2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout bench did not finish");
        $fatal(1, "global timeout");
    end

    // driver tasks: called at a negedge, return at a later negedge
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        sys_rst   = 1'b1;
        start     = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        @(negedge clk);
        sys_rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic store(input int port, input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] data);
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we[port*4 +: 4]     = we;
        mem_addr[port*32 +: 32] = addr;
        mem_wdata[port*32 +: 32] = data;
        @(negedge clk);
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
    endtask

    task automatic store2(input logic [31:0] d0, input logic [31:0] d1);
        mem_we    = 8'hFF;
        mem_addr  = {32'h1000, 32'h1000};
        mem_wdata = {d1, d0};
        @(negedge clk);
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy, done, status, fail_code, cycle_count, halt_req} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got b=%0b d=%0b s=%0d fc=%0h cc=%0d h=%0b exp all 0",
                     busy, done, status, fail_code, cycle_count, halt_req);
        end
        checks++;
        if (state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL reset_state got %0d exp 0", state_dbg);
        end
    endtask

    task automatic test_pass();
        logic [32:0] exp;
        int w;
        do_reset();
        pulse_start();
        checks++;
        if ({busy, done, cycle_count, state_dbg} !== {1'b1, 1'b0, 32'd0, 3'd1}) begin
            errors++;
            $display("FAIL pass_run_entry got b=%0b d=%0b cc=%0d st=%0d exp 1 0 0 1",
                     busy, done, cycle_count, state_dbg);
        end
        exp_q.push_back({2'd1, 31'd0});
        store(0, 4'hF, 32'h1000, 32'h1);
        w = 0;
        while (!done && w < 4) begin @(negedge clk); w++; end
        exp = exp_q.pop_front();
        checks++;
        if ({status, fail_code} !== exp) begin
            errors++;
            $display("FAIL pass_result got %0h exp %0h", {status, fail_code}, exp);
        end
        checks++;
        if ({busy, done, halt_req} !== 3'b011) begin
            errors++;
            $display("FAIL pass_flags got b=%0b d=%0b h=%0b exp 0 1 1", busy, done, halt_req);
        end
    endtask

    task automatic test_fail();
        logic [32:0] exp;
        int w;
        do_reset();
        pulse_start();
        idle(3);
        exp_q.push_back({2'd2, 31'd3});
        store(0, 4'hF, 32'h1000, 32'h7);
        w = 0;
        while (!done && w < 4) begin @(negedge clk); w++; end
        exp = exp_q.pop_front();
        checks++;
        if ({status, fail_code} !== exp) begin
            errors++;
            $display("FAIL fail_result got %0h exp %0h", {status, fail_code}, exp);
        end
        store(0, 4'hF, 32'h1000, 32'h1);
        pulse_start();
        checks++;
        if ({busy, done, status, fail_code, cycle_count} !== {1'b0, 1'b1, 2'd2, 31'd3, 32'd3}) begin
            errors++;
            $display("FAIL fail_sticky got b=%0b d=%0b s=%0d fc=%0d cc=%0d exp 0 1 2 3 3",
                     busy, done, status, fail_code, cycle_count);
        end
    endtask

    task automatic test_clear_and_enables();
        logic [32:0] exp;
        int w;
        do_reset();
        pulse_start();
        store(0, 4'hF, 32'h1000, 32'h0);
        store(0, 4'h0, 32'h1000, 32'h7);
        store(0, 4'hF, 32'h1004, 32'h7);
        checks++;
        if ({busy, done, status} !== {1'b1, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL clear_ignored got b=%0b d=%0b s=%0d exp 1 0 0", busy, done, status);
        end
        exp_q.push_back({2'd1, 31'd0});
        store(0, 4'b0001, 32'h1000, 32'h1);
        w = 0;
        while (!done && w < 4) begin @(negedge clk); w++; end
        exp = exp_q.pop_front();
        checks++;
        if ({status, fail_code} !== exp) begin
            errors++;
            $display("FAIL single_byte_pass got %0h exp %0h", {status, fail_code}, exp);
        end
    endtask

    task automatic test_timeout();
        logic [32:0] exp;
        int w;
        do_reset();
        exp_q.push_back({2'd3, 31'd0});
        pulse_start();
        idle(15);
        checks++;
        if ({busy, done, cycle_count} !== {1'b1, 1'b0, 32'd15}) begin
            errors++;
            $display("FAIL timeout_before got b=%0b d=%0b cc=%0d exp 1 0 15",
                     busy, done, cycle_count);
        end
        idle(1);
        exp = exp_q.pop_front();
        checks++;
        if ({status, fail_code} !== exp) begin
            errors++;
            $display("FAIL timeout_result got %0h exp %0h", {status, fail_code}, exp);
        end
        checks++;
        if (cycle_count !== 32'd15) begin
            errors++;
            $display("FAIL timeout_count got %0d exp 15", cycle_count);
        end
        do_reset();
        pulse_start();
        idle(15);
        exp_q.push_back({2'd1, 31'd0});
        store(1, 4'hF, 32'h1000, 32'h1);
        w = 0;
        while (!done && w < 4) begin @(negedge clk); w++; end
        exp = exp_q.pop_front();
        checks++;
        if ({status, fail_code, cycle_count} !== {exp, 32'd15}) begin
            errors++;
            $display("FAIL timeout_last_hit got s=%0d fc=%0d cc=%0d exp %0h cc 15",
                     status, fail_code, cycle_count, exp);
        end
    endtask

    task automatic test_multi_port();
        logic [32:0] exp;
        logic [31:0] d0 [3];
        logic [31:0] d1 [3];
        logic [32:0] e  [3];
        int w;
        d0[0] = 32'h5; d1[0] = 32'h1; e[0] = {2'd2, 31'd2};
        d0[1] = 32'h0; d1[1] = 32'h1; e[1] = {2'd1, 31'd0};
        d0[2] = 32'h1; d1[2] = 32'h9; e[2] = {2'd1, 31'd0};
        for (int i = 0; i < 3; i++) begin
            do_reset();
            pulse_start();
            exp_q.push_back(e[i]);
            store2(d0[i], d1[i]);
            w = 0;
            while (!done && w < 4) begin @(negedge clk); w++; end
            exp = exp_q.pop_front();
            checks++;
            if ({status, fail_code} !== exp) begin
                errors++;
                $display("FAIL multi_port_%0d got %0h exp %0h", i, {status, fail_code}, exp);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        pulse_start();
        idle(10);
        checks++;
        if ({busy, cycle_count} !== {1'b1, 32'd10}) begin
            errors++;
            $display("FAIL mid_run_count got b=%0b cc=%0d exp 1 10", busy, cycle_count);
        end
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
        checks++;
        if ({busy, done, status, fail_code, cycle_count, halt_req} !== '0) begin
            errors++;
            $display("FAIL mid_run_reset got b=%0b d=%0b s=%0d cc=%0d exp all 0",
                     busy, done, status, cycle_count);
        end
        store(0, 4'hF, 32'h1000, 32'h1);
        idle(2);
        checks++;
        if ({busy, done, status, fail_code, cycle_count, halt_req} !== '0) begin
            errors++;
            $display("FAIL idle_store_ignored got b=%0b d=%0b s=%0d exp all 0",
                     busy, done, status);
        end
    endtask

    task automatic test_random();
        logic [32:0] exp;
        logic [31:0] val;
        int n, port, w;
        for (int i = 0; i < 6; i++) begin
            do_reset();
            pulse_start();
            n = $urandom_range(0, 10);
            idle(n);
            port = $urandom_range(0, 1);
            val = $urandom;
            if (val == 32'd0 || $urandom_range(0, 2) == 0) val = 32'd1;
            if (val == 32'd1) exp_q.push_back({2'd1, 31'd0});
            else exp_q.push_back({2'd2, val[31:1]});
            store(port, 4'(1 << $urandom_range(0, 3)), 32'h1000, val);
            w = 0;
            while (!done && w < 4) begin @(negedge clk); w++; end
            exp = exp_q.pop_front();
            checks++;
            if ({status, fail_code, cycle_count} !== {exp, 32'(n)}) begin
                errors++;
                $display("FAIL random_%0d got s=%0d fc=%0h cc=%0d exp %0h cc %0d",
                         i, status, fail_code, cycle_count, exp, n);
            end
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        idle(20);
        checks++;
        if ({busy2, done2, cycle_count2} !== {1'b1, 1'b0, 4'hF}) begin
            errors++;
            $display("FAIL sat_count got b=%0b d=%0b cc=%0d exp 1 0 15",
                     busy2, done2, cycle_count2);
        end
        we2 = 4'hF; addr2 = 32'h1000; wdata2 = 32'h1;
        @(negedge clk);
        we2 = '0; addr2 = '0; wdata2 = '0;
        checks++;
        if ({done2, status2, cycle_count2, halt_req2} !== {1'b1, 2'd1, 4'hF, 1'b1}) begin
            errors++;
            $display("FAIL sat_pass got d=%0b s=%0d cc=%0d h=%0b exp 1 1 15 1",
                     done2, status2, cycle_count2, halt_req2);
        end
    endtask

    initial begin
        sys_rst = 1'b1; start = 1'b0; mem_we = '0; mem_addr = '0; mem_wdata = '0;
        rst2 = 1'b1; start2 = 1'b0; we2 = '0; addr2 = '0; wdata2 = '0;
        test_reset();
        test_pass();
        test_fail();
        test_clear_and_enables();
        test_timeout();
        test_multi_port();
        test_reset_mid_run();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
